// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Streams a program (up to 16 bytes) from a valid/ready byte source into a
// 16 x 8 RAM through the MAR / RAM-write strobes of a simple CPU, holding the
// CPU sequencer and PC in clear until the load finishes. Each byte takes
// exactly three cycles: ACCEPT (handshake), SET_MAR (load MAR), WRITE (RAM
// write).
//
// Ports
//   clk          in   system clock, rising edge
//   low_clr      in   asynchronous active-low reset (release synchronised)
//   start        in   begin a new load (honoured only in IDLE / DONE)
//   in_valid     in   in_data / in_last valid
//   in_data[7:0] in   program byte
//   in_last      in   final byte of the program
//   in_ready     out  loader accepts a byte this cycle
//   mar_addr[3:0]out  RAM address presented to the MAR
//   low_ld_mar   out  MAR load strobe, active-low
//   ram_wr_data  out  byte presented to the RAM
//   low_ram_we   out  RAM write strobe, active-low
//   low_cpu_clr  out  holds CPU sequencer and PC in clear while low
//   done         out  load complete
//   overflow_err out  more data bytes offered than the RAM holds
//   csum_err     out  checksum mismatch (always 0 without checksum mode)
//
// Build option
//   LOADER_CHECKSUM_EN  when defined, the in_last byte is a checksum that is
//                       not written; the 8-bit sum of all bytes including the
//                       checksum must be zero, otherwise csum_err is raised
//                       and the CPU stays in clear.
// ---------------------------------------------------------------------------
module program_loader (
  input  logic       clk,
  input  logic       low_clr,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic [3:0] mar_addr,
  output logic       low_ld_mar,
  output logic [7:0] ram_wr_data,
  output logic       low_ram_we,
  output logic       low_cpu_clr,
  output logic       done,
  output logic       overflow_err,
  output logic       csum_err
);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    SET_MAR,
    WRITE,
    DONE
  } state_t;

  state_t     r_state;
  logic [1:0] r_rstSync;
  logic       w_rstN;
  logic       w_xfer;
  logic [3:0] r_addr;
  logic [7:0] r_sum;
`ifdef LOADER_CHECKSUM_EN
  logic       r_full;
  logic [7:0] w_csumTotal;
`else
  logic       r_last;
`endif

  // Reset asserts immediately but releases two clock edges after low_clr
  // rises, so the FSM never leaves reset on a metastable edge.
  always_ff @(posedge clk or negedge low_clr) begin
    if (!low_clr) r_rstSync <= 2'b00;
    else          r_rstSync <= {r_rstSync[0], 1'b1};
  end

  assign w_rstN = r_rstSync[1];
  assign w_xfer = in_valid & in_ready;

`ifdef LOADER_CHECKSUM_EN
  assign w_csumTotal = r_sum + in_data;
`else
  assign csum_err = 1'b0;
`endif

  // All outputs are registered: each transition loads the outputs belonging
  // to the state being entered, so strobes last exactly one state (one cycle).
  always_ff @(posedge clk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_state      <= IDLE;
      r_addr       <= 4'h0;
      r_sum        <= 8'h00;
      in_ready     <= 1'b0;
      low_ld_mar   <= 1'b1;
      low_ram_we   <= 1'b1;
      mar_addr     <= 4'h0;
      ram_wr_data  <= 8'h00;
      low_cpu_clr  <= 1'b0;
      done         <= 1'b0;
      overflow_err <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_err     <= 1'b0;
      r_full       <= 1'b0;
`else
      r_last       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state      <= ACCEPT;
            r_addr       <= 4'h0;
            r_sum        <= 8'h00;
            done         <= 1'b0;
            overflow_err <= 1'b0;
            low_cpu_clr  <= 1'b0;
            in_ready     <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_err     <= 1'b0;
            r_full       <= 1'b0;
`endif
          end
        end

        ACCEPT: begin
          if (w_xfer) begin
            in_ready <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            // The checksum byte ends the load without touching RAM; a data
            // byte arriving after address 15 was written is an overflow.
            if (in_last) begin
              r_state     <= DONE;
              done        <= 1'b1;
              csum_err    <= (w_csumTotal != 8'h00);
              low_cpu_clr <= (w_csumTotal == 8'h00);
            end else if (r_full) begin
              r_state      <= DONE;
              done         <= 1'b1;
              overflow_err <= 1'b1;
              low_cpu_clr  <= 1'b1;
            end else begin
              r_state     <= SET_MAR;
              ram_wr_data <= in_data;
              low_ld_mar  <= 1'b0;
              mar_addr    <= r_addr;
            end
`else
            r_state     <= SET_MAR;
            r_last      <= in_last;
            ram_wr_data <= in_data;
            low_ld_mar  <= 1'b0;
            mar_addr    <= r_addr;
`endif
          end
        end

        SET_MAR: begin
          r_state    <= WRITE;
          low_ld_mar <= 1'b1;
          low_ram_we <= 1'b0;
        end

        WRITE: begin
          low_ram_we <= 1'b1;
          r_sum      <= r_sum + ram_wr_data;
`ifdef LOADER_CHECKSUM_EN
          // Address 15 is terminal: remember that RAM is full and go back
          // for the checksum instead of wrapping the counter.
          r_state  <= ACCEPT;
          in_ready <= 1'b1;
          if (r_addr == 4'hF) r_full <= 1'b1;
          else                r_addr <= r_addr + 4'h1;
`else
          if (r_last) begin
            r_state     <= DONE;
            done        <= 1'b1;
            low_cpu_clr <= 1'b1;
          end else if (r_addr == 4'hF) begin
            r_state      <= DONE;
            done         <= 1'b1;
            overflow_err <= 1'b1;
            low_cpu_clr  <= 1'b1;
          end else begin
            r_state  <= ACCEPT;
            r_addr   <= r_addr + 4'h1;
            in_ready <= 1'b1;
          end
`endif
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: drives program bytes through the valid/ready
// port, records the expected (address, byte) RAM writes in a scoreboard queue
// and compares them when the write strobe appears.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       low_clr;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic [3:0] mar_addr;
  logic       low_ld_mar;
  logic [7:0] ram_wr_data;
  logic       low_ram_we;
  logic       low_cpu_clr;
  logic       done;
  logic       overflow_err;
  logic       csum_err;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t sbQ[$];
  int   total = 0;
  int   bad = 0;
  int   writeCount = 0;
  int   ldMarCount = 0;
  int   expIdx = 0;

  always #5 clk = ~clk;

  program_loader dut (
    .clk          (clk),
    .low_clr      (low_clr),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .mar_addr     (mar_addr),
    .low_ld_mar   (low_ld_mar),
    .ram_wr_data  (ram_wr_data),
    .low_ram_we   (low_ram_we),
    .low_cpu_clr  (low_cpu_clr),
    .done         (done),
    .overflow_err (overflow_err),
    .csum_err     (csum_err)
  );

  // Counts a comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", tag, actual, expected);
    end
  endtask

  // All outputs against their reset values in one packed comparison.
  task automatic checkResetVals(input string tag);
    checkOutput(tag,
      {13'd0, in_ready, low_ld_mar, low_ram_we, low_cpu_clr, done,
       overflow_err, csum_err, mar_addr, ram_wr_data},
      {13'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00});
  endtask

  // Scoreboard side: every strobe is checked against the oldest expected
  // write, and a strobe with nothing expected is a failure on its own.
  always @(negedge clk) begin
    if (low_clr === 1'b1) begin
      if (!low_ld_mar && !low_ram_we) checkOutput("strobeOverlap", 1, 0);
      if (in_ready && (!low_ld_mar || !low_ram_we)) checkOutput("readyDuringStrobe", 1, 0);
      if (!low_ld_mar) begin
        ldMarCount++;
        if (sbQ.size() == 0) checkOutput("ldMarUnexpected", 1, 0);
        else                 checkOutput("ldMarAddr", mar_addr, sbQ[0].addr);
      end
      if (!low_ram_we) begin
        writeCount++;
        if (sbQ.size() == 0) checkOutput("writeUnexpected", 1, 0);
        else begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput("writeAddr", mar_addr, e.addr);
          checkOutput("writeData", ram_wr_data, e.data);
        end
      end
    end
  end

  // Pulses start for one cycle; tStart is the time of the sampling edge.
  task automatic startLoad(output time tStart);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    tStart = $time;
    #1 start = 1'b0;
    expIdx = 0;
  endtask

  // Offers one byte, optionally after a gap of idle cycles, and waits for the
  // handshake. Bytes that should reach RAM are pushed to the scoreboard.
  task automatic applyStimulus(input logic [7:0] d, input logic last,
                               input int gap, input bit expectWrite);
    bit ok;
    in_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
      checkOutput("gapReadyHeld", in_ready, 1);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checkOutput("readyTimeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (expectWrite) begin
      exp_t e;
      e.addr = expIdx[3:0];
      e.data = d;
      sbQ.push_back(e);
      expIdx++;
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Waits for done; if expCycles > 0 also checks edges from start to done.
  task automatic waitDone(input time tStart, input int expCycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("doneSeen", ok, 1);
    if (ok && expCycles > 0)
      checkOutput("doneLatency", 32'(($time - tStart - 5) / 10), expCycles);
  endtask

  initial begin
    time tStart;
    int  wc0;
    int  lm0;
    bit  ok;

    low_clr  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    #12;
    checkResetVals("resetVals");
    @(negedge clk) low_clr = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("idleReady", in_ready, 0);
    checkOutput("idleCpuClr", low_cpu_clr, 0);

`ifndef LOADER_CHECKSUM_EN
    // Basic three-byte load.
    wc0 = writeCount; lm0 = ldMarCount;
    startLoad(tStart);
    checkOutput("cpuClrDuringLoad", low_cpu_clr, 0);
    applyStimulus(8'h1D, 1'b0, 0, 1'b1);
    applyStimulus(8'h2E, 1'b0, 0, 1'b1);
    applyStimulus(8'hE0, 1'b1, 0, 1'b1);
    waitDone(tStart, 9);
    checkOutput("basicCpuClr", low_cpu_clr, 1);
    checkOutput("basicOverflow", overflow_err, 0);
    checkOutput("basicReady", in_ready, 0);
    checkOutput("basicWrites", writeCount - wc0, 3);
    checkOutput("basicLdMar", ldMarCount - lm0, 3);
    checkOutput("basicSbEmpty", sbQ.size(), 0);

    // start held while a load is in progress must not restart it.
    wc0 = writeCount;
    startLoad(tStart);
    applyStimulus(8'h11, 1'b0, 0, 1'b1);
    start = 1'b1;
    repeat (4) @(posedge clk);
    #1 start = 1'b0;
    applyStimulus(8'h22, 1'b0, 0, 1'b1);
    applyStimulus(8'h33, 1'b1, 0, 1'b1);
    waitDone(tStart, 0);
    checkOutput("startIgnWrites", writeCount - wc0, 3);
    checkOutput("startIgnSbEmpty", sbQ.size(), 0);

    // Gapped source: same RAM contents, no extra strobes.
    wc0 = writeCount; lm0 = ldMarCount;
    startLoad(tStart);
    applyStimulus(8'h1D, 1'b0, 0, 1'b1);
    applyStimulus(8'h2E, 1'b0, 5, 1'b1);
    applyStimulus(8'hE0, 1'b1, 5, 1'b1);
    waitDone(tStart, 0);
    checkOutput("gapWrites", writeCount - wc0, 3);
    checkOutput("gapLdMar", ldMarCount - lm0, 3);
    checkOutput("gapSbEmpty", sbQ.size(), 0);
    checkOutput("gapCpuClr", low_cpu_clr, 1);

    // Sixteen bytes with no in_last: fills RAM then flags overflow.
    wc0 = writeCount;
    startLoad(tStart);
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'h40 + i), 1'b0, 0, 1'b1);
    waitDone(tStart, 0);
    checkOutput("ovfFlag", overflow_err, 1);
    checkOutput("ovfCpuClr", low_cpu_clr, 1);
    checkOutput("ovfWrites", writeCount - wc0, 16);
    checkOutput("ovfSbEmpty", sbQ.size(), 0);
    in_valid = 1'b1; in_data = 8'h99;
    repeat (4) @(negedge clk);
    checkOutput("ovfNoReady", in_ready, 0);
    checkOutput("ovfDoneHeld", done, 1);
    in_valid = 1'b0;
`else
    // Good checksum: 0x10 + 0x20 + 0xD0 = 0 mod 256.
    wc0 = writeCount;
    startLoad(tStart);
    checkOutput("cpuClrDuringLoad", low_cpu_clr, 0);
    applyStimulus(8'h10, 1'b0, 0, 1'b1);
    applyStimulus(8'h20, 1'b0, 0, 1'b1);
    applyStimulus(8'hD0, 1'b1, 0, 1'b0);
    waitDone(tStart, 0);
    checkOutput("csumOkErr", csum_err, 0);
    checkOutput("csumOkCpuClr", low_cpu_clr, 1);
    checkOutput("csumOkWrites", writeCount - wc0, 2);
    checkOutput("csumOkSbEmpty", sbQ.size(), 0);

    // Bad checksum keeps the CPU in clear.
    wc0 = writeCount;
    startLoad(tStart);
    applyStimulus(8'h10, 1'b0, 0, 1'b1);
    applyStimulus(8'h20, 1'b0, 0, 1'b1);
    applyStimulus(8'hD1, 1'b1, 0, 1'b0);
    waitDone(tStart, 0);
    checkOutput("csumBadErr", csum_err, 1);
    checkOutput("csumBadCpuClr", low_cpu_clr, 0);
    checkOutput("csumBadWrites", writeCount - wc0, 2);

    // Seventeenth non-last byte after a full RAM is an overflow.
    wc0 = writeCount;
    startLoad(tStart);
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'h40 + i), 1'b0, 0, 1'b1);
    checkOutput("fullNotDone", done, 0);
    applyStimulus(8'h77, 1'b0, 0, 1'b0);
    waitDone(tStart, 0);
    checkOutput("ovfFlag", overflow_err, 1);
    checkOutput("ovfCsum", csum_err, 0);
    checkOutput("ovfWrites", writeCount - wc0, 16);
    checkOutput("ovfSbEmpty", sbQ.size(), 0);
`endif

    // Reset during the WRITE of the third byte aborts immediately.
    startLoad(tStart);
    applyStimulus(8'hA0, 1'b0, 0, 1'b1);
    applyStimulus(8'hA1, 1'b0, 0, 1'b1);
    applyStimulus(8'hA2, 1'b0, 0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!low_ram_we && mar_addr == 4'h2) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("thirdWriteSeen", ok, 1);
    #1 low_clr = 1'b0;
    #1 checkResetVals("midLoadResetVals");
    wc0 = writeCount; lm0 = ldMarCount;
    repeat (3) @(posedge clk);
    @(negedge clk) low_clr = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("postResetWrites", writeCount - wc0, 0);
    checkOutput("postResetLdMar", ldMarCount - lm0, 0);
    checkOutput("postResetReady", in_ready, 0);
    checkOutput("postResetSbEmpty", sbQ.size(), 0);
    checkResetVals("postResetVals");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have port: clk  in  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: low_clr  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have port: start  in  1  begin new load; sampled only in IDLE or DONE.
REQ-004 SHALL have port: in_valid  in  1  in_data/in_last valid.
REQ-005 SHALL have port: in_data  in  8  program byte.
REQ-006 SHALL have port: in_last  in  1  final byte of program.
REQ-007 SHALL have port: in_ready  out  1  loader accepts byte; transfer when in_valid & in_ready.
REQ-008 SHALL have port: mar_addr  out  4  RAM address driven to MAR.
REQ-009 SHALL have port: low_ld_mar  out  1  load MAR, active-low.
REQ-010 SHALL have port: ram_wr_data  out  8  data to RAM.
REQ-011 SHALL have port: low_ram_we  out  1  RAM write enable, active-low.
REQ-012 SHALL have port: low_cpu_clr  out  1  holds sequencer and PC in clear while low.
REQ-013 SHALL have port: done  out  1  load complete.
REQ-014 SHALL have port: overflow_err  out  1  more than 16 data bytes offered.
REQ-015 SHALL have port: csum_err  out  1  checksum mismatch (see Configuration).

Function
REQ-016 SHALL implement states IDLE, ACCEPT, SET_MAR, WRITE, DONE.
REQ-017 IDLE/DONE: start=1 SHALL clear addr counter, done, overflow_err, csum_err, running sum; drive low_cpu_clr=0; next state ACCEPT.
REQ-018 ACCEPT: in_ready=1; on transfer SHALL capture in_data and in_last into registers, next SET_MAR; no transfer -> stay.
REQ-019 SET_MAR: low_ld_mar=0 for exactly one cycle, mar_addr=addr counter; next WRITE.
REQ-020 WRITE: low_ram_we=0 for exactly one cycle, ram_wr_data=captured byte, mar_addr unchanged; add byte to 8-bit running sum (mod 256).
REQ-021 After WRITE: captured in_last=1 -> DONE; else addr=15 -> DONE with overflow_err=1; else addr+1, ACCEPT.
REQ-022 Throughput SHALL be exactly 3 cycles per byte with in_valid held high.
REQ-023 DONE: done=1, low_cpu_clr=1 (unless csum_err), in_ready=0; remain until start.
REQ-024 in_ready, low_ld_mar, low_ram_we SHALL be inactive in every state not named above for them; strobes never overlap.
REQ-025 start outside IDLE/DONE SHALL be ignored; in_valid outside ACCEPT SHALL be ignored (no data lost, source holds).
REQ-026 Address counter SHALL never wrap; 4-bit value 15 is terminal.

Reset
REQ-027 low_clr=0 SHALL asynchronously force IDLE, addr=0, sum=0, in_ready=0, low_ld_mar=1, low_ram_we=1, mar_addr=0, ram_wr_data=0, low_cpu_clr=0, done=0, overflow_err=0, csum_err=0.
REQ-028 Reset mid-load SHALL abort immediately with no further RAM strobes; reset deassertion SHALL be synchronised internally with a 2-flop release.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN SHALL select checksum mode.
REQ-030 Defined: byte with in_last=1 is a checksum, not written; ACCEPT on it goes directly to DONE; csum_err=1 if (sum+checksum) mod 256 != 0, and low_cpu_clr stays 0 in DONE.
REQ-031 Defined: after writing addr 15 with non-last byte, SHALL return to ACCEPT for checksum; a following byte with in_last=0 sets overflow_err, goes DONE.
REQ-032 Not defined: in_last byte is ordinary data per REQ-021; csum_err tied 0.

Verification
REQ-033 Reset, start, bytes 0x1D,0x2E,0xE0(last) -> writes 0x1D@0,0x2E@1,0xE0@2, 9 cycles, done=1, low_cpu_clr=1.
REQ-034 16 bytes, last without in_last -> 16 writes, overflow_err=1 (no macro).
REQ-035 in_valid gapped 5 cycles between bytes -> in_ready held, no extra strobes, same RAM contents.
REQ-036 low_clr pulsed low during WRITE of byte 3 -> all outputs at reset values same cycle, no further strobes.
REQ-037 Macro: bytes 0x10,0x20, checksum 0xD0(last) -> 2 writes, csum_err=0; checksum 0xD1 -> csum_err=1, low_cpu_clr=0.
REQ-038 start during ACCEPT -> ignored, load continues unchanged.
